// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32I-subset datapath (lw, sw, R/I ALU, beq) with a
// shared ALU and unified memory port, plus memory-stall watchdog and sticky trap flags.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 255,
   parameter int WDOG_W      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctrl,
   output logic [1:0] result_src,
   output logic [1:0] imm_src,
   output logic       illegal,
   output logic       timeout,
   output logic [3:0] state_dbg
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      TRAP     = 4'd15
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(MEM_TIMEOUT - 1);
   localparam bit                WDOG_EN   = (MEM_TIMEOUT != 0);

   state_t            state, state_next;
   logic [WDOG_W-1:0] wdog_cnt;
   logic              wdog_expire, mem_wait;
   logic              req_raw, we_raw, ir_raw, pc_raw, rw_raw;
   logic              set_illegal, set_timeout;
   logic              is_lw, is_sw, is_beq, alu_ok;
   logic [2:0]        alu_op;

   assign is_lw       = (opcode == OP_LOAD)  && (funct3 == 3'b010);
   assign is_sw       = (opcode == OP_STORE) && (funct3 == 3'b010);
   assign is_beq      = (opcode == OP_BR)    && (funct3 == 3'b000);
   // The counter value equals the number of wait cycles already elapsed.
   assign wdog_expire = WDOG_EN && (wdog_cnt == WDOG_LAST);

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      alu_op = ALU_ADD;
      alu_ok = 1'b1;
      case (funct3)
         3'b000:  alu_op = (state == EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  alu_op = ALU_SLT;
         3'b110:  alu_op = ALU_OR;
         3'b111:  alu_op = ALU_AND;
         default: alu_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_next  = state;
      req_raw     = 1'b0;
      we_raw      = 1'b0;
      ir_raw      = 1'b0;
      pc_raw      = 1'b0;
      rw_raw      = 1'b0;
      adr_src     = 1'b0;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_ctrl    = ALU_ADD;
      result_src  = 2'b00;
      imm_src     = 2'b11;
      mem_wait    = 1'b0;
      set_illegal = 1'b0;
      set_timeout = 1'b0;
      case (state)
         FETCH: begin
            req_raw    = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            mem_wait   = 1'b1;
            if (mem_ready) begin
               ir_raw     = 1'b1;
               pc_raw     = 1'b1;
               state_next = DECODE;
            end else if (wdog_expire) begin
               state_next  = TRAP;
               set_timeout = 1'b1;
            end
         end
         DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            imm_src   = 2'b10;
            if (is_lw || is_sw)      state_next = MEMADR;
            else if (opcode == OP_R) state_next = EXECR;
            else if (opcode == OP_I) state_next = EXECI;
            else if (is_beq)         state_next = BEQ;
            else begin
               state_next  = TRAP;
               set_illegal = 1'b1;
            end
         end
         MEMADR: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            imm_src    = is_sw ? 2'b01 : 2'b00;
            state_next = is_sw ? MEMWRITE : MEMREAD;
         end
         MEMREAD, MEMWRITE: begin
            req_raw  = 1'b1;
            we_raw   = (state == MEMWRITE);
            adr_src  = 1'b1;
            mem_wait = 1'b1;
            if (mem_ready) begin
               state_next = (state == MEMREAD) ? MEMWB : FETCH;
            end else if (wdog_expire) begin
               state_next  = TRAP;
               set_timeout = 1'b1;
            end
         end
         MEMWB: begin
            result_src = 2'b01;
            rw_raw     = 1'b1;
            state_next = FETCH;
         end
         EXECR, EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = (state == EXECI) ? 2'b01 : 2'b00;
            imm_src   = (state == EXECI) ? 2'b00 : 2'b11;
            alu_ctrl  = alu_op;
            if (alu_ok) state_next = ALUWB;
            else begin
               state_next  = TRAP;
               set_illegal = 1'b1;
            end
         end
         ALUWB: begin
            rw_raw     = 1'b1;
            state_next = FETCH;
         end
         BEQ: begin
            alu_src_a  = 2'b10;
            alu_ctrl   = ALU_SUB;
            pc_raw     = zero;
            state_next = FETCH;
         end
         TRAP:    state_next = TRAP;
         default: state_next = TRAP;
      endcase
   end

   // Reset kills strobes combinationally so an aborted instruction issues nothing more.
   assign mem_req   = req_raw & ~rst;
   assign mem_we    = we_raw  & ~rst;
   assign ir_write  = ir_raw  & ~rst;
   assign pc_write  = pc_raw  & ~rst;
   assign reg_write = rw_raw  & ~rst;
   assign state_dbg = state;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FETCH;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog_cnt <= '0;
      end else if (mem_wait && !mem_ready && state_next == state) begin
         wdog_cnt <= wdog_cnt + WDOG_W'(1);
      end else begin
         wdog_cnt <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal <= 1'b0;
         timeout <= 1'b0;
      end else begin
         if (set_illegal) illegal <= 1'b1;
         if (set_timeout) timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed cycle-by-cycle bench: each step queues its stimulus and the expected control
// word; the drain loop applies the stimulus and compares the DUT against the queue head.
module tb_multicycle_ctrl;

   typedef struct packed {
      logic [3:0] st;
      logic       req, we, adr, irw, pcw, rw;
      logic [1:0] a, b;
      logic [2:0] alu;
      logic [1:0] res, imm;
      logic       ill, to;
   } ctl_t;

   typedef struct {
      logic  rs, mr, z;
      ctl_t  e;
      string tag;
   } item_t;

   logic       clk, rst;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5, zero, mem_ready;
   logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
   logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
   logic [2:0] alu_ctrl;
   logic       illegal, timeout;
   logic [3:0] state_dbg;

   item_t sb[$];
   int    passed = 0;
   int    total  = 0;
   int    failed = 0;
   logic  exp_ill = 1'b0;
   logic  exp_to  = 1'b0;

   multicycle_ctrl #(.MEM_TIMEOUT(4), .WDOG_W(8)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
      .result_src(result_src), .imm_src(imm_src), .illegal(illegal), .timeout(timeout),
      .state_dbg(state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ctl_t c(input logic [3:0] st, input logic req, we, adr, irw, pcw, rw,
                              input logic [1:0] a, b, input logic [2:0] alu,
                              input logic [1:0] res, imm);
      ctl_t r;
      r = '{st, req, we, adr, irw, pcw, rw, a, b, alu, res, imm, exp_ill, exp_to};
      return r;
   endfunction

   // Expected control word per state, written from the state table.
   function automatic ctl_t e_reset();               return c(0, 0,0,0,0,0,0, 2'b00,2'b10,3'b000,2'b10,2'b11); endfunction
   function automatic ctl_t e_fetch(input logic rdy); return c(0, 1,0,0,rdy,rdy,0, 2'b00,2'b10,3'b000,2'b10,2'b11); endfunction
   function automatic ctl_t e_decode();              return c(1, 0,0,0,0,0,0, 2'b01,2'b01,3'b000,2'b00,2'b10); endfunction
   function automatic ctl_t e_memadr(input logic [1:0] imm); return c(2, 0,0,0,0,0,0, 2'b10,2'b01,3'b000,2'b00,imm); endfunction
   function automatic ctl_t e_memread();             return c(3, 1,0,1,0,0,0, 2'b00,2'b00,3'b000,2'b00,2'b11); endfunction
   function automatic ctl_t e_memwb();               return c(4, 0,0,0,0,0,1, 2'b00,2'b00,3'b000,2'b01,2'b11); endfunction
   function automatic ctl_t e_memwrite();            return c(5, 1,1,1,0,0,0, 2'b00,2'b00,3'b000,2'b00,2'b11); endfunction
   function automatic ctl_t e_execr(input logic [2:0] alu); return c(6, 0,0,0,0,0,0, 2'b10,2'b00,alu,2'b00,2'b11); endfunction
   function automatic ctl_t e_execi(input logic [2:0] alu); return c(7, 0,0,0,0,0,0, 2'b10,2'b01,alu,2'b00,2'b00); endfunction
   function automatic ctl_t e_aluwb();               return c(8, 0,0,0,0,0,1, 2'b00,2'b00,3'b000,2'b00,2'b11); endfunction
   function automatic ctl_t e_beq(input logic z);    return c(9, 0,0,0,0,z,0, 2'b10,2'b00,3'b001,2'b00,2'b11); endfunction
   function automatic ctl_t e_trap();                return c(15,0,0,0,0,0,0, 2'b00,2'b00,3'b000,2'b00,2'b11); endfunction

   task automatic push(input logic rs, input logic mr, input logic z, input ctl_t e, input string tag);
      item_t it;
      it.rs = rs; it.mr = mr; it.z = z; it.e = e; it.tag = tag;
      sb.push_back(it);
   endtask

   task automatic check(input item_t it);
      ctl_t act;
      act = {state_dbg, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
             alu_src_a, alu_src_b, alu_ctrl, result_src, imm_src, illegal, timeout};
      total++;
      assert (act === it.e) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed st=%0d word=%b expected st=%0d word=%b",
                it.tag, act.st, act, it.e.st, it.e);
      end
   endtask

   // Applies each queued stimulus on the falling edge and checks the settled outputs.
   task automatic drain();
      item_t it;
      while (sb.size() > 0) begin
         it = sb.pop_front();
         @(negedge clk);
         rst = it.rs; mem_ready = it.mr; zero = it.z;
         #1;
         check(it);
      end
   endtask

   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      opcode = op; funct3 = f3; funct7b5 = f7;
   endtask

   initial begin
      rst = 1'b1; mem_ready = 1'b0; zero = 1'b0;
      set_instr(7'b0, 3'b0, 1'b0);

      push(1, 1, 0, e_reset(), "reset_hold0");
      push(1, 1, 0, e_reset(), "reset_hold1");
      drain();

      set_instr(7'b0110011, 3'b000, 1'b0);
      push(0, 1, 0, e_fetch(1), "add_fetch");
      push(0, 1, 0, e_decode(), "add_decode");
      push(0, 1, 0, e_execr(3'b000), "add_execr");
      push(0, 1, 0, e_aluwb(), "add_aluwb");
      drain();

      set_instr(7'b0110011, 3'b000, 1'b1);
      push(0, 1, 0, e_fetch(1), "sub_fetch");
      push(0, 1, 0, e_decode(), "sub_decode");
      push(0, 1, 0, e_execr(3'b001), "sub_execr");
      push(0, 1, 0, e_aluwb(), "sub_aluwb");
      drain();

      set_instr(7'b0110011, 3'b110, 1'b0);
      push(0, 1, 0, e_fetch(1), "or_fetch");
      push(0, 1, 0, e_decode(), "or_decode");
      push(0, 1, 0, e_execr(3'b011), "or_execr");
      push(0, 1, 0, e_aluwb(), "or_aluwb");
      drain();

      set_instr(7'b0010011, 3'b010, 1'b1);
      push(0, 1, 0, e_fetch(1), "slti_fetch");
      push(0, 1, 0, e_decode(), "slti_decode");
      push(0, 1, 0, e_execi(3'b101), "slti_execi");
      push(0, 1, 0, e_aluwb(), "slti_aluwb");
      drain();

      set_instr(7'b0010011, 3'b000, 1'b1);
      push(0, 1, 0, e_fetch(1), "addi_fetch");
      push(0, 1, 0, e_decode(), "addi_decode");
      push(0, 1, 0, e_execi(3'b000), "addi_execi_nosub");
      push(0, 1, 0, e_aluwb(), "addi_aluwb");
      drain();

      set_instr(7'b0010011, 3'b111, 1'b0);
      push(0, 1, 0, e_fetch(1), "andi_fetch");
      push(0, 1, 0, e_decode(), "andi_decode");
      push(0, 1, 0, e_execi(3'b010), "andi_execi");
      push(0, 1, 0, e_aluwb(), "andi_aluwb");
      drain();

      set_instr(7'b0000011, 3'b010, 1'b0);
      push(0, 1, 0, e_fetch(1), "lw_fetch");
      push(0, 1, 0, e_decode(), "lw_decode");
      push(0, 1, 0, e_memadr(2'b00), "lw_memadr");
      for (int i = 0; i < 3; i++) push(0, 0, 0, e_memread(), "lw_memread_wait");
      push(0, 1, 0, e_memread(), "lw_memread_done");
      push(0, 1, 0, e_memwb(), "lw_memwb");
      drain();

      set_instr(7'b0100011, 3'b010, 1'b0);
      push(0, 1, 0, e_fetch(1), "sw_fetch");
      push(0, 1, 0, e_decode(), "sw_decode");
      push(0, 1, 0, e_memadr(2'b01), "sw_memadr");
      push(0, 1, 0, e_memwrite(), "sw_memwrite");
      drain();

      set_instr(7'b1100011, 3'b000, 1'b0);
      push(0, 1, 0, e_fetch(1), "beq_t_fetch");
      push(0, 1, 0, e_decode(), "beq_t_decode");
      push(0, 1, 1, e_beq(1), "beq_taken");
      push(0, 1, 0, e_fetch(1), "beq_n_fetch");
      push(0, 1, 0, e_decode(), "beq_n_decode");
      push(0, 1, 0, e_beq(0), "beq_not_taken");
      drain();

      // Ready arriving in the expiry cycle completes the fetch normally.
      set_instr(7'b0110011, 3'b000, 1'b0);
      for (int i = 0; i < 3; i++) push(0, 0, 0, e_fetch(0), "wd_fetch_wait");
      push(0, 1, 0, e_fetch(1), "wd_fetch_ready_at_expiry");
      push(0, 1, 0, e_decode(), "wd_decode");
      push(0, 1, 0, e_execr(3'b000), "wd_execr");
      push(0, 1, 0, e_aluwb(), "wd_aluwb");
      drain();

      for (int i = 0; i < 4; i++) push(0, 0, 0, e_fetch(0), "to_fetch_wait");
      exp_to = 1'b1;
      push(0, 1, 0, e_trap(), "to_trap0");
      push(0, 1, 0, e_trap(), "to_trap_hold");
      exp_to = 1'b0;
      push(1, 1, 0, e_reset(), "to_reset_clears");
      drain();

      set_instr(7'b1111111, 3'b000, 1'b0);
      push(0, 1, 0, e_fetch(1), "badop_fetch");
      push(0, 1, 0, e_decode(), "badop_decode");
      exp_ill = 1'b1;
      push(0, 1, 0, e_trap(), "badop_trap0");
      push(0, 1, 0, e_trap(), "badop_trap_hold");
      exp_ill = 1'b0;
      push(1, 1, 0, e_reset(), "badop_reset_clears");
      drain();

      set_instr(7'b0110011, 3'b001, 1'b0);
      push(0, 1, 0, e_fetch(1), "badf3_fetch");
      push(0, 1, 0, e_decode(), "badf3_decode");
      push(0, 1, 0, e_execr(3'b000), "badf3_execr");
      exp_ill = 1'b1;
      push(0, 1, 0, e_trap(), "badf3_trap_no_regwrite");
      push(0, 1, 0, e_trap(), "badf3_trap_hold");
      exp_ill = 1'b0;
      push(1, 1, 0, e_reset(), "badf3_reset_clears");
      drain();

      // Reset asserted in MEMADR aborts the load at once.
      set_instr(7'b0000011, 3'b010, 1'b0);
      push(0, 1, 0, e_fetch(1), "abort_fetch");
      push(0, 1, 0, e_decode(), "abort_decode");
      push(1, 1, 0, e_reset(), "abort_reset_in_memadr");
      push(0, 1, 0, e_fetch(1), "rerun_fetch");
      push(0, 1, 0, e_decode(), "rerun_decode");
      push(0, 1, 0, e_memadr(2'b00), "rerun_memadr");
      push(0, 1, 0, e_memread(), "rerun_memread");
      push(0, 1, 0, e_memwb(), "rerun_memwb");
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
